// File: rtl/busca_pkg.sv
// -----------------------------------------------------------------------------
// busca_pkg -- shared definitions for the successive-approximation searcher.
//   state_t        : FSM state encoding (IDLE, TEST, DONE)
//   BUSCA_N_STATES : number of FSM states
// -----------------------------------------------------------------------------
package busca_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TEST = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int BUSCA_N_STATES = 3;

endpackage : busca_pkg

// File: rtl/comparador.sv
// -----------------------------------------------------------------------------
// comparador -- combinational unsigned magnitude comparator.
// Ports:
//   a, b   : unsigned operands (WIDTH bits)
//   maior  : a > b
//   menor  : a < b
//   igual  : a == b
// -----------------------------------------------------------------------------
module comparador #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             maior,
  output logic             menor,
  output logic             igual
);

  assign maior = (a > b);
  assign menor = (a < b);
  assign igual = (a == b);

endmodule : comparador

// File: rtl/busca_sar.sv
// -----------------------------------------------------------------------------
// busca_sar -- successive-approximation search initiator.
//
// Drives a trial value (palpite) to an external comparator and resolves one
// bit per clock from MSB to LSB, using the comparator's maior/menor/igual
// answer sampled on the following edge.
//
// Handshake: start is sampled only in IDLE; a search then occupies exactly
// the TEST cycles (busy high), enters DONE for one cycle, and done pulses
// for one cycle on the edge leaving DONE. start seen in TEST or DONE is
// dropped, never queued. valor and erro hold until the next accepted start.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : request a new search (IDLE only)
//   maior/menor/igual : comparator answer for the current palpite
//   palpite        : registered trial value to the comparator
//   valor          : search result
//   busy           : high while in TEST
//   done           : one-cycle completion pulse
//   erro           : comparator answer was not exactly one-hot
//   o_dbg_state    : current FSM state, for observation only
//
// Configuration macro: BUSCA_SAR_EARLY_EXIT_EN -- when defined, an igual
// answer ends the search immediately with valor = palpite.
// -----------------------------------------------------------------------------
module busca_sar
  import busca_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             maior,
  input  logic             menor,
  input  logic             igual,
  output logic [WIDTH-1:0] palpite,
  output logic [WIDTH-1:0] valor,
  output logic             busy,
  output logic             done,
  output logic             erro,
  output state_t           o_dbg_state
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0]    IDX_MSB  = IW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef BUSCA_SAR_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  state_t           r_state;
  logic [WIDTH-1:0] r_palpite;
  logic [WIDTH-1:0] r_result;   // bits already resolved (above r_idx)
  logic [WIDTH-1:0] r_valor;
  logic [IW-1:0]    r_idx;
  logic             r_busy;
  logic             r_done;
  logic             r_erro;

  logic [1:0]       w_hits;
  logic             w_onehot;
  logic [WIDTH-1:0] w_bit_sel;
  logic [WIDTH-1:0] w_result_next;
  logic [WIDTH-1:0] w_guess_next;

  // palpite is always r_result with the bit under test set, so keeping the
  // bit means OR-ing it into r_result and clearing it means leaving it out.
  always_comb begin
    w_hits        = {1'b0, maior} + {1'b0, menor} + {1'b0, igual};
    w_onehot      = (w_hits == 2'd1);
    w_bit_sel     = WIDTH'(1) << r_idx;
    w_result_next = (maior || igual) ? (r_result | w_bit_sel) : r_result;
    // Shifting the selector right lands on bit i-1; at i=0 it is unused.
    w_guess_next  = w_result_next | (w_bit_sel >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_palpite <= '0;
      r_result  <= '0;
      r_valor   <= '0;
      r_idx     <= IDX_MSB;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_erro    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_result  <= '0;
            r_erro    <= 1'b0;
            r_idx     <= IDX_MSB;
            r_palpite <= MSB_ONLY;
            r_busy    <= 1'b1;
            r_state   <= ST_TEST;
          end
        end
        ST_TEST: begin
          if (!w_onehot) begin
            r_erro  <= 1'b1;
            r_valor <= r_result;
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end else if (EARLY_EXIT && igual) begin
            r_result <= r_palpite;
            r_valor  <= r_palpite;
            r_busy   <= 1'b0;
            r_state  <= ST_DONE;
          end else if (r_idx == '0) begin
            r_result <= w_result_next;
            r_valor  <= w_result_next;
            r_busy   <= 1'b0;
            r_state  <= ST_DONE;
          end else begin
            r_result  <= w_result_next;
            r_palpite <= w_guess_next;
            r_idx     <= r_idx - IW'(1);
          end
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign palpite     = r_palpite;
  assign valor       = r_valor;
  assign busy        = r_busy;
  assign done        = r_done;
  assign erro        = r_erro;
  assign o_dbg_state = r_state;

endmodule : busca_sar

// File: doc/busca_sar.md
BUSCA_SAR -- requirements
Module: busca_sar

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning bit width of the searched value and of the guess bus.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  request a new search; sampled only in IDLE.
REQ-005 SHALL have port maior  input  1  external comparator result: target > palpite.
REQ-006 SHALL have port menor  input  1  external comparator result: target < palpite.
REQ-007 SHALL have port igual  input  1  external comparator result: target == palpite.
REQ-008 SHALL have port palpite  output  WIDTH  registered guess driven to comparator B input.
REQ-009 SHALL have port valor  output  WIDTH  search result, held until next start.
REQ-010 SHALL have port busy  output  1  high while in TEST.
REQ-011 SHALL have port done  output  1  one-cycle pulse on search completion.
REQ-012 SHALL have port erro  output  1  comparator response invalid during last search; held until next start.

Function
REQ-013 SHALL act as the initiator of the comparator interface: it drives palpite and reads maior/menor/igual, which are combinational on palpite and are sampled on the following clock edge.
REQ-014 SHALL implement FSM states IDLE, TEST, DONE; IDLE->TEST on start; TEST->DONE after bit 0 is resolved, on early exit or on error; DONE->IDLE unconditionally after one cycle.
REQ-015 On start in IDLE SHALL clear the result register and erro, set bit index to WIDTH-1 and load palpite with only the MSB set (8 for WIDTH=4).
REQ-016 In TEST, per cycle, at bit index i: maior -> keep bit i; menor -> clear bit i; igual -> keep bit i; then set bit i-1 in palpite and decrement i.
REQ-017 Exactly-one-hot check: if the count of asserted maior/menor/igual in a TEST sample is not exactly 1, SHALL set erro=1, leave valor at the result register's current value, and go to DONE.
REQ-018 Latency: without early exit done SHALL assert exactly WIDTH+1 edges after the edge sampling start (the edge entering DONE is WIDTH edges after start); busy high for exactly WIDTH cycles.
REQ-019 valor SHALL update on the edge entering DONE and hold stable through IDLE until the next accepted start.
REQ-020 start while busy or in DONE SHALL be ignored (no queuing).
REQ-021 Comparator inputs SHALL be ignored outside TEST.
REQ-022 Arithmetic is unsigned; palpite and valor never exceed 2^WIDTH-1.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, palpite=0, valor=0, busy=0, done=0, erro=0, bit index WIDTH-1, including mid-search; no done pulse is produced for an aborted search.

Configuration
REQ-024 Macro BUSCA_SAR_EARLY_EXIT_EN defined: igual sampled in TEST SHALL end the search, load valor=palpite and go to DONE on that edge.
REQ-025 Macro undefined: igual is treated per REQ-016 and every search takes exactly WIDTH TEST cycles.

Structure
REQ-026 FSM state encoding and the state-count constant SHALL live in shared package busca_pkg.
REQ-027 Single module; no sub-module is required, and the bench SHALL instantiate the team's existing 4-bit comparator (comparador) as the responder.

Verification
REQ-028 Target 0, macro undefined: start -> palpite sequence 8,4,2,1; done 5 edges after start; valor=0; erro=0.
REQ-029 Target 15, macro undefined: palpite 8,12,14,15; valor=15; done 5 edges after start; with BUSCA_SAR_EARLY_EXIT_EN same sequence and timing (match on last bit).
REQ-030 Target 8 with BUSCA_SAR_EARLY_EXIT_EN: igual on first TEST cycle -> done 2 edges after start, valor=8, busy high 1 cycle.
REQ-031 Exhaustive targets 0..15, both macro settings: valor equals target every time, erro=0.
REQ-032 Forced maior=menor=1 on second TEST cycle -> erro=1, done pulse next cycle, busy drops; next start clears erro.
REQ-033 rst_n pulsed low during third TEST cycle -> all outputs 0 asynchronously, no done; subsequent start with target 5 yields valor=5.
